// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one
// 64-bit physical-memory port, assembling 4-beat 256-bit lines.
module cache_arbiter #(
   parameter int BEATS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_read,
   input  logic [31:0]  i_addr,
   output logic [255:0] i_rdata,
   output logic         i_resp,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [31:0]  d_addr,
   input  logic [255:0] d_wdata,
   output logic [255:0] d_rdata,
   output logic         d_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [63:0]  pmem_wdata,
   input  logic [63:0]  pmem_rdata,
   input  logic         pmem_resp
);

   typedef enum logic [2:0] {
      IDLE,
      I_FILL,
      D_FILL,
      D_WB,
      DONE
   } state_t;

   localparam logic [1:0] LAST = 2'(BEATS - 1);

   state_t       state_q;
   logic [1:0]   k_q;
   logic         last_d_q;
   logic         serve_d_q;
   logic         rd_q;
   logic         wr_q;
   logic         iresp_q;
   logic         dresp_q;
   logic [31:0]  addr_q;
   logic [255:0] line_q;
   logic [255:0] line_d;
   logic [255:0] i_line_q;
   logic [255:0] d_line_q;
   logic         d_req;

   assign d_req = d_read | d_write;

   // Line buffer with the current beat merged in.
   always_comb begin
      line_d = line_q;
      line_d[{k_q, 6'b0} +: 64] = pmem_rdata;
   end

   // Grant, burst sequencing and completion handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= 2'd0;
         last_d_q  <= 1'b0;
         serve_d_q <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         iresp_q   <= 1'b0;
         dresp_q   <= 1'b0;
         addr_q    <= 32'd0;
         line_q    <= 256'd0;
         i_line_q  <= 256'd0;
         d_line_q  <= 256'd0;
      end else begin
         iresp_q <= 1'b0;
         dresp_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               k_q <= 2'd0;
               if (d_req && (!i_read || !last_d_q)) begin
                  serve_d_q <= 1'b1;
                  addr_q    <= {d_addr[31:5], 5'b0};
                  if (d_write) begin
                     state_q <= D_WB;
                     wr_q    <= 1'b1;
                     line_q  <= d_wdata;
                  end else begin
                     state_q <= D_FILL;
                     rd_q    <= 1'b1;
                  end
               end else if (i_read) begin
                  serve_d_q <= 1'b0;
                  addr_q    <= {i_addr[31:5], 5'b0};
                  state_q   <= I_FILL;
                  rd_q      <= 1'b1;
               end
            end
            I_FILL, D_FILL: begin
               if (pmem_resp) begin
                  line_q <= line_d;
                  k_q    <= k_q + 2'd1;
                  if (k_q == LAST) begin
                     state_q <= DONE;
                     rd_q    <= 1'b0;
                     if (serve_d_q) begin
                        d_line_q <= line_d;
                        dresp_q  <= 1'b1;
                     end else begin
                        i_line_q <= line_d;
                        iresp_q  <= 1'b1;
                     end
                  end
               end
            end
            D_WB: begin
               if (pmem_resp) begin
                  k_q <= k_q + 2'd1;
                  if (k_q == LAST) begin
                     state_q <= DONE;
                     wr_q    <= 1'b0;
                     dresp_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               last_d_q <= serve_d_q;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wr_q ? line_q[{k_q, 6'b0} +: 64] : 64'd0;
   assign i_rdata      = i_line_q;
   assign d_rdata      = d_line_q;
   assign i_resp       = iresp_q;
   assign d_resp       = dresp_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a memory model answers bursts,
// drivers queue expected lines, a monitor checks every completion.
module tb_cache_arbiter;

   typedef struct {
      logic [31:0]  addr;
      logic         wb;
      logic [255:0] line;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read;
   logic [31:0]  i_addr;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [31:0]  d_addr;
   logic [255:0] d_wdata;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [63:0]  pmem_wdata;
   logic [63:0]  pmem_rdata;
   logic         pmem_resp;

   int checks = 0;
   int failures = 0;
   int beat = 0;
   int wcnt = 0;
   int fixed_wait = -1;
   bit fixed_mode = 1'b0;

   exp_t         exp_i[$];
   exp_t         exp_d[$];
   bit           exp_order[$];
   logic [63:0]  wb_seen[$];
   logic [255:0] last_dline = '0;

   cache_arbiter #(.BEATS(4)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   // Memory contents: a fixed pattern per line address and beat.
   function automatic logic [63:0] beat_of(input logic [31:0] a,
                                           input int k);
      if (fixed_mode) return {8{8'((k + 1) * 17)}};
      return {a ^ 32'hC0DE_0000 ^ (32'(k) * 32'h0101_0101),
              ~a + 32'(k) * 32'h1357};
   endfunction

   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 4; k++)
         l[64*k +: 64] = beat_of({a[31:5], 5'b0}, k);
      return l;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   // Physical memory: random wait states, stray strobes when idle.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         pmem_resp = 1'b0;
         if (rst || !(pmem_read || pmem_write)) begin
            beat = 0;
            wcnt = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) begin
               pmem_resp  = 1'b1;
               pmem_rdata = {$urandom, $urandom};
            end
         end else begin
            if (pmem_write)
               chk("wdata_beat", 256'(pmem_wdata),
                   256'(d_wdata[64*beat +: 64]));
            if (wcnt == 0) begin
               pmem_resp  = 1'b1;
               pmem_rdata = beat_of(pmem_address, beat);
               if (pmem_write) wb_seen.push_back(pmem_wdata);
               beat++;
               wcnt = (fixed_wait >= 0) ? fixed_wait
                                        : int'($urandom_range(0, 3));
            end else begin
               wcnt--;
            end
         end
      end
   end

   // Monitor: burst tracking and completion scoreboard.
   initial begin
      logic        prev_cmd = 1'b0;
      logic        prev_ir = 1'b0;
      logic        prev_dr = 1'b0;
      logic        b_wr = 1'b0;
      logic [31:0] b_addr = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         chk("rw_excl", 256'(pmem_read & pmem_write), '0);
         chk("resp_excl", 256'(i_resp & d_resp), '0);
         if ((pmem_read || pmem_write) && !prev_cmd) begin
            b_addr = pmem_address;
            b_wr   = pmem_write;
         end else if (pmem_read || pmem_write) begin
            chk("addr_stable", 256'(pmem_address), 256'(b_addr));
            chk("cmd_type", 256'(pmem_write), 256'(b_wr));
         end
         prev_cmd = pmem_read | pmem_write;
         if ((i_resp || d_resp) && exp_order.size() > 0)
            chk("order", 256'(d_resp), 256'(exp_order.pop_front()));
         if (i_resp) begin
            chk("i_resp_width", 256'(prev_ir), '0);
            if (exp_i.size() == 0) begin
               chk("i_resp_unexp", 256'(i_resp), '0);
            end else begin
               e = exp_i.pop_front();
               chk("i_addr", 256'(b_addr), 256'(e.addr));
               chk("i_type", 256'(b_wr), '0);
               chk("i_rdata", i_rdata, e.line);
            end
         end
         if (d_resp) begin
            chk("d_resp_width", 256'(prev_dr), '0);
            if (exp_d.size() == 0) begin
               chk("d_resp_unexp", 256'(d_resp), '0);
            end else begin
               e = exp_d.pop_front();
               chk("d_addr", 256'(b_addr), 256'(e.addr));
               chk("d_type", 256'(b_wr), 256'(e.wb));
               if (e.wb) begin
                  chk("wb_beats", 256'(wb_seen.size()), 256'(4));
                  if (wb_seen.size() == 4)
                     chk("wb_data", {wb_seen[3], wb_seen[2],
                                     wb_seen[1], wb_seen[0]}, e.line);
                  chk("d_rdata_hold", d_rdata, last_dline);
               end else begin
                  chk("d_rdata", d_rdata, e.line);
                  last_dline = e.line;
               end
            end
            wb_seen.delete();
         end
         prev_ir = i_resp;
         prev_dr = d_resp;
      end
   end

   task automatic i_req(input logic [31:0] a, input logic [255:0] l,
                        input bit drop1);
      bit done = 1'b0;
      i_addr = a;
      i_read = 1'b1;
      exp_i.push_back('{{a[31:5], 5'b0}, 1'b0, l});
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (drop1 && beat >= 1 && pmem_read) i_read = 1'b0;
         if (i_resp) begin
            done = 1'b1;
            break;
         end
      end
      chk("i_timeout", 256'(done), 256'(1));
      i_read = 1'b0;
   endtask

   task automatic d_req(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [255:0] wd);
      bit done = 1'b0;
      d_addr  = a;
      d_wdata = wd;
      d_read  = rd;
      d_write = wr;
      exp_d.push_back('{{a[31:5], 5'b0}, wr, wr ? wd : line_of(a)});
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (d_resp) begin
            done = 1'b1;
            break;
         end
      end
      chk("d_timeout", 256'(done), 256'(1));
      d_read  = 1'b0;
      d_write = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_cmd"}, 256'({pmem_read, pmem_write, i_resp, d_resp}), '0);
      chk({nm, "_addr"}, 256'(pmem_address), '0);
      chk({nm, "_wdata"}, 256'(pmem_wdata), '0);
      chk({nm, "_irdata"}, i_rdata, '0);
      chk({nm, "_drdata"}, d_rdata, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      exp_i.delete();
      exp_d.delete();
      exp_order.delete();
      wb_seen.delete();
      last_dline = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit ok;
      rst = 1'b1;
      i_read = 1'b0; i_addr = '0;
      d_read = 1'b0; d_write = 1'b0;
      d_addr = '0;   d_wdata = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      i_read = 1'b1; d_read = 1'b1; d_write = 1'b1;
      d_wdata = rnd256();
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk_zero("rst_held");
      end
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      rst = 1'b0;

      fixed_mode = 1'b1;
      i_req(32'h0000_1234,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
            1'b0);
      fixed_mode = 1'b0;

      do_reset();
      exp_order.push_back(1'b1);
      exp_order.push_back(1'b0);
      exp_order.push_back(1'b1);
      exp_order.push_back(1'b0);
      fork
         begin
            i_req(32'h0000_4000, line_of(32'h0000_4000), 1'b0);
            i_req(32'h0000_4100, line_of(32'h0000_4100), 1'b0);
         end
         begin
            d_req(32'h8000_0040, 1'b1, 1'b0, '0);
            d_req(32'h8000_0060, 1'b1, 1'b0, '0);
         end
      join
      chk("order_drained", 256'(exp_order.size()), '0);

      fixed_wait = 2;
      d_req(32'h9000_00A0, 1'b0, 1'b1,
            {64'hDDDD_DDDD_0000_0004, 64'hCCCC_CCCC_0000_0003,
             64'hBBBB_BBBB_0000_0002, 64'hAAAA_AAAA_0000_0001});
      fixed_wait = -1;

      d_req(32'h9000_1000, 1'b1, 1'b1, rnd256());

      d_addr = 32'hA000_0200;
      d_read = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (pmem_read && beat >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("abort_wait", 256'(ok), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      d_read = 1'b0;
      wb_seen.delete();
      @(negedge clk);
      chk_zero("abort");
      rst = 1'b0;
      last_dline = '0;
      d_req(32'hA000_0200, 1'b1, 1'b0, '0);

      i_req(32'h0000_7780, line_of(32'h0000_7780), 1'b1);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk("idle_after_drop", 256'({pmem_read, pmem_write}), '0);
      end

      fork
         for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            begin
               logic [31:0] a;
               a = $urandom;
               i_req(a, line_of(a), 1'b0);
            end
         end
         for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            begin
               int op;
               op = $urandom_range(0, 2);
               d_req($urandom, op != 1, op != 0, rnd256());
            end
         end
      join

      repeat (5) @(negedge clk);
      chk("exp_i_drained", 256'(exp_i.size()), '0);
      chk("exp_d_drained", 256'(exp_d.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: BEATS, 4, number of 64-bit pmem beats per 256-bit cache line (fixed at 4; other values unsupported).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_read  input  1  I-cache line-fill request, held until i_resp.
REQ-005 i_addr  input  32  I-cache miss address.
REQ-006 i_rdata  output  256  assembled fill line to I-cache.
REQ-007 i_resp  output  1  one-cycle completion pulse to I-cache.
REQ-008 d_read  input  1  D-cache line-fill request, held until d_resp.
REQ-009 d_write  input  1  D-cache writeback request, held until d_resp.
REQ-010 d_addr  input  32  D-cache line address.
REQ-011 d_wdata  input  256  D-cache writeback line.
REQ-012 d_rdata  output  256  assembled fill line to D-cache.
REQ-013 d_resp  output  1  one-cycle completion pulse to D-cache.
REQ-014 pmem_read, pmem_write  output  1 each  physical-memory burst commands.
REQ-015 pmem_address  output  32  line-aligned burst address.
REQ-016 pmem_wdata  output  64  current write beat; pmem_rdata  input  64  current read beat.
REQ-017 pmem_resp  input  1  beat accepted/valid strobe from physical memory.

Function
REQ-018 SHALL implement states IDLE, I_FILL, D_FILL, D_WB, DONE.
REQ-019 IDLE: request sampled at edge t SHALL move to the granted state at t; pmem command asserted from cycle t+1.
REQ-020 Arbitration: D-side SHALL win when only D pending or when both pending and the last served side was I; I SHALL win when only I pending or both pending and last served was D (last_served resets to I).
REQ-021 d_write and d_read both high SHALL select D_WB.
REQ-022 pmem_address SHALL equal {granted_addr[31:5], 5'b0}, latched at grant and constant for the whole burst.
REQ-023 I_FILL/D_FILL SHALL hold pmem_read=1; each pmem_resp SHALL write pmem_rdata into line[64*k+63:64*k], k = 2-bit beat counter, then increment k.
REQ-024 D_WB SHALL hold pmem_write=1 with pmem_wdata = d_wdata[64*k+63:64*k]; k increments on each pmem_resp.
REQ-025 pmem_read and pmem_write SHALL never be high together; both low in IDLE and DONE.
REQ-026 Cycles without pmem_resp SHALL hold state, k and line buffer unchanged (indefinite wait permitted).
REQ-027 On pmem_resp with k=3: k wraps to 0, state SHALL go to DONE.
REQ-028 DONE SHALL pulse exactly one of i_resp/d_resp for one cycle, update last_served, then return to IDLE; no new grant in DONE.
REQ-029 i_rdata/d_rdata SHALL present the assembled line during DONE and hold it until the next fill of that side completes.
REQ-030 Request deasserted mid-burst SHALL be ignored: burst completes and resp still pulses.
REQ-031 Back-to-back: request still high in IDLE after its resp SHALL be treated as a new request.
REQ-032 pmem_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-033 rst high at an edge SHALL force IDLE, k=0, last_served=I, line buffers 0, all outputs 0 next cycle, aborting any burst without resp.
REQ-034 rst held high SHALL keep all outputs 0 regardless of requests.

Verification
REQ-035 I-only fill, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address 0x0000_1220, i_rdata {0x44..,0x33..,0x22..,0x11..}, i_resp one cycle, d_resp 0.
REQ-036 i_read and d_read same cycle after reset -> D served first (last_served=I), then I; still both pending -> D again.
REQ-037 D writeback, d_wdata beats A,B,C,D with 2 wait cycles between pmem_resp -> pmem_wdata steps A,B,C,D only on pmem_resp; d_resp once.
REQ-038 rst asserted after beat 2 of a D fill -> next cycle IDLE, pmem_read 0, no d_resp; reissued request restarts at k=0.
REQ-039 i_read dropped after beat 1 -> burst completes, i_resp pulses once, arbiter returns to IDLE idle.
REQ-040 d_read and d_write both high -> pmem_write asserted, pmem_read never asserted.
